// File: rtl/rotating_priority_resolver.sv
// rtl/rotating_priority_resolver.sv - rotating-priority, fully-nested interrupt resolver with INT/INTA handshake
module rotating_priority_resolver #(
    parameter int NUM_IRQ = 8,
    parameter int LVL_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irr,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic               aeoi,
    input  logic               rot_en,
    input  logic               eoi,
    input  logic               seoi,
    input  logic [LVL_W-1:0]   eoi_id,
    input  logic               set_prio,
    input  logic [LVL_W-1:0]   set_prio_id,
    input  logic               inta,
    output logic               int_out,
    output logic [NUM_IRQ-1:0] ack_vec,
    output logic [LVL_W-1:0]   ack_id,
    output logic               spurious,
    output logic [NUM_IRQ-1:0] isr,
    output logic [LVL_W-1:0]   lowest_id
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

    state_t             state_q;
    logic               int_q;
    logic [NUM_IRQ-1:0] ack_vec_q;
    logic [LVL_W-1:0]   ack_id_q;
    logic               spur_q;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic [LVL_W-1:0]   lowest_q, lowest_d;

    logic [NUM_IRQ-1:0] cand;
    logic               win_valid;
    logic [LVL_W-1:0]   win_id, win_rank;
    logic [NUM_IRQ-1:0] win_onehot;
    logic               top_valid;
    logic [LVL_W-1:0]   top_id, top_rank;
    logic [LVL_W-1:0]   ch;
    logic               req_cond;
    logic               ack_fire;
    logic [NUM_IRQ-1:0] isr_clr, isr_set;
    logic               eoi_act;
    logic [LVL_W-1:0]   eoi_ch;

    assign cand = irr & ~imr;

    // Walk from lowest rank to highest so the final hit is the highest-priority one.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        win_rank  = '0;
        top_valid = 1'b0;
        top_id    = '0;
        top_rank  = '0;
        ch        = '0;
        for (int r = NUM_IRQ - 1; r >= 0; r--) begin
            ch = lowest_q + LVL_W'(r + 1);
            if (cand[ch]) begin
                win_valid = 1'b1;
                win_id    = ch;
                win_rank  = LVL_W'(r);
            end
            if (isr_q[ch]) begin
                top_valid = 1'b1;
                top_id    = ch;
                top_rank  = LVL_W'(r);
            end
        end
    end

    assign win_onehot = NUM_IRQ'(1) << win_id;
    assign req_cond   = win_valid && (!top_valid || (win_rank < top_rank));
    assign ack_fire   = (state_q == S_REQ) && inta && win_valid;

    // Specific EOI overrides a simultaneous non-specific one.
    always_comb begin
        isr_clr = '0;
        eoi_act = 1'b0;
        eoi_ch  = '0;
        if (seoi) begin
            isr_clr[eoi_id] = 1'b1;
            eoi_act         = 1'b1;
            eoi_ch          = eoi_id;
        end else if (eoi && top_valid) begin
            isr_clr[top_id] = 1'b1;
            eoi_act         = 1'b1;
            eoi_ch          = top_id;
        end
    end

    assign isr_set = (ack_fire && !aeoi) ? win_onehot : '0;
    assign isr_d   = (isr_q & ~isr_clr) | isr_set;

    always_comb begin
        lowest_d = lowest_q;
        if (set_prio) begin
            lowest_d = set_prio_id;
        end else if (ack_fire && aeoi && rot_en) begin
            lowest_d = win_id;
        end else if (eoi_act && rot_en) begin
            lowest_d = eoi_ch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            int_q     <= 1'b0;
            ack_vec_q <= '0;
            ack_id_q  <= '0;
            spur_q    <= 1'b0;
            isr_q     <= '0;
            lowest_q  <= LVL_W'(NUM_IRQ - 1);
        end else begin
            isr_q     <= isr_d;
            lowest_q  <= lowest_d;
            ack_vec_q <= '0;
            spur_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_cond) begin
                        state_q <= S_REQ;
                        int_q   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (inta) begin
                        state_q <= S_ACK;
                        int_q   <= 1'b0;
                        if (win_valid) begin
                            ack_vec_q <= win_onehot;
                            ack_id_q  <= win_id;
                        end else begin
                            spur_q   <= 1'b1;
                            ack_id_q <= LVL_W'(NUM_IRQ - 1);
                        end
                    end else if (!req_cond) begin
                        state_q <= S_IDLE;
                        int_q   <= 1'b0;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    int_q   <= 1'b0;
                end
            endcase
        end
    end

    assign int_out   = int_q;
    assign ack_vec   = ack_vec_q;
    assign ack_id    = ack_id_q;
    assign spurious  = spur_q;
    assign isr       = isr_q;
    assign lowest_id = lowest_q;

endmodule

// File: tb/tb_rotating_priority_resolver.sv
// tb/tb_rotating_priority_resolver.sv - table-driven bench for rotating_priority_resolver
module tb_rotating_priority_resolver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irr, imr;
    logic       aeoi, rot_en, eoi, seoi;
    logic [2:0] eoi_id;
    logic       set_prio;
    logic [2:0] set_prio_id;
    logic       inta;
    logic       int_out;
    logic [7:0] ack_vec;
    logic [2:0] ack_id;
    logic       spurious;
    logic [7:0] isr;
    logic [2:0] lowest_id;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rotating_priority_resolver #(.NUM_IRQ(8), .LVL_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr), .aeoi(aeoi), .rot_en(rot_en),
        .eoi(eoi), .seoi(seoi), .eoi_id(eoi_id), .set_prio(set_prio), .set_prio_id(set_prio_id),
        .inta(inta), .int_out(int_out), .ack_vec(ack_vec), .ack_id(ack_id), .spurious(spurious),
        .isr(isr), .lowest_id(lowest_id)
    );

    typedef struct {
        logic [7:0] irr, imr;
        logic       aeoi, rot_en, eoi, seoi;
        logic [2:0] eoi_id;
        logic       set_prio;
        logic [2:0] set_prio_id;
        logic       inta;
        logic       e_int;
        logic [7:0] e_ackv;
        logic [2:0] e_ackid;
        logic       e_sp;
        logic [7:0] e_isr;
        logic [2:0] e_low;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [7:0] i_irr, input logic [7:0] i_imr, input logic i_aeoi,
                       input logic i_rot, input logic i_eoi, input logic i_seoi, input logic [2:0] i_eid,
                       input logic i_sp, input logic [2:0] i_spid, input logic i_inta,
                       input logic x_int, input logic [7:0] x_ackv, input logic [2:0] x_ackid,
                       input logic x_sp, input logic [7:0] x_isr, input logic [2:0] x_low);
        vec_t v;
        v.irr = i_irr; v.imr = i_imr; v.aeoi = i_aeoi; v.rot_en = i_rot; v.eoi = i_eoi;
        v.seoi = i_seoi; v.eoi_id = i_eid; v.set_prio = i_sp; v.set_prio_id = i_spid; v.inta = i_inta;
        v.e_int = x_int; v.e_ackv = x_ackv; v.e_ackid = x_ackid; v.e_sp = x_sp; v.e_isr = x_isr;
        v.e_low = x_low;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    endtask

    task automatic check_all(input int idx, input logic x_int, input logic [7:0] x_ackv,
                             input logic [2:0] x_ackid, input logic x_sp, input logic [7:0] x_isr,
                             input logic [2:0] x_low);
        chk("int_out", idx, 8'(int_out), 8'(x_int));
        chk("ack_vec", idx, ack_vec, x_ackv);
        chk("ack_id", idx, 8'(ack_id), 8'(x_ackid));
        chk("spurious", idx, 8'(spurious), 8'(x_sp));
        chk("isr", idx, isr, x_isr);
        chk("lowest_id", idx, 8'(lowest_id), 8'(x_low));
    endtask

    task automatic idle_inputs();
        irr = 8'h00; imr = 8'h00; aeoi = 1'b0; rot_en = 1'b0; eoi = 1'b0; seoi = 1'b0;
        eoi_id = 3'd0; set_prio = 1'b0; set_prio_id = 3'd0; inta = 1'b0;
    endtask

    initial begin
        //   irr    imr    ae ro eo se id sp pid ia | int ackv   aid sp isr    low
        add(8'h14, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,    1, 8'h00, 0, 0, 8'h00, 7); // 0
        add(8'h14, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1,    0, 8'h04, 2, 0, 8'h04, 7); // 1
        add(8'h10, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 2, 0, 8'h04, 7); // 2
        add(8'h10, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 2, 0, 8'h04, 7); // 3 nested block
        add(8'h11, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,    1, 8'h00, 2, 0, 8'h04, 7); // 4
        add(8'h11, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1,    0, 8'h01, 0, 0, 8'h05, 7); // 5
        add(8'h10, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 0, 0, 8'h05, 7); // 6
        add(8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0,    0, 8'h00, 0, 0, 8'h04, 7); // 7 eoi clears ch0
        add(8'h00, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0,    0, 8'h00, 0, 0, 8'h00, 2); // 8 eoi+rotate
        add(8'h06, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0,    1, 8'h00, 0, 0, 8'h00, 2); // 9
        add(8'h06, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1,    0, 8'h02, 1, 0, 8'h02, 2); // 10 ch1 beats ch2
        add(8'h04, 8'h00, 0, 0, 0, 1, 1, 0, 0, 0,    0, 8'h00, 1, 0, 8'h00, 2); // 11 seoi ch1
        add(8'h08, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,    1, 8'h00, 1, 0, 8'h00, 2); // 12
        add(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1,    0, 8'h00, 7, 1, 8'h00, 2); // 13 spurious
        add(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 7, 0, 8'h00, 2); // 14
        add(8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,    1, 8'h00, 7, 0, 8'h00, 2); // 15
        add(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 7, 0, 8'h00, 2); // 16 withdrawn
        add(8'h80, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0,    1, 8'h00, 7, 0, 8'h00, 2); // 17
        add(8'h80, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1,    0, 8'h80, 7, 0, 8'h00, 7); // 18 aeoi rotate
        add(8'h00, 8'h00, 0, 1, 0, 1, 5, 1, 3, 0,    0, 8'h00, 7, 0, 8'h00, 3); // 19 set_prio wins
        add(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1,    0, 8'h00, 7, 0, 8'h00, 3); // 20 inta in idle
        add(8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,    1, 8'h00, 7, 0, 8'h00, 3); // 21
        add(8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1,    0, 8'h01, 0, 0, 8'h01, 3); // 22
        add(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 0, 0, 8'h01, 3); // 23
        add(8'h20, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,    1, 8'h00, 0, 0, 8'h01, 3); // 24
        add(8'h20, 8'h00, 0, 0, 1, 0, 0, 0, 0, 1,    0, 8'h20, 5, 0, 8'h20, 3); // 25 eoi+inta
        add(8'h00, 8'h00, 0, 0, 1, 1, 3, 0, 0, 0,    0, 8'h00, 5, 0, 8'h20, 3); // 26 seoi beats eoi
        add(8'h10, 8'h10, 0, 0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 5, 0, 8'h20, 3); // 27 masked
        add(8'h10, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,    1, 8'h00, 5, 0, 8'h20, 3); // 28
        add(8'h10, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1,    0, 8'h10, 4, 0, 8'h30, 3); // 29
        add(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 4, 0, 8'h30, 3); // 30
        add(8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0,    0, 8'h00, 4, 0, 8'h20, 3); // 31
        add(8'h10, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,    1, 8'h00, 4, 0, 8'h20, 3); // 32 in REQ

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all(-1, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd7);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            irr = vq[i].irr; imr = vq[i].imr; aeoi = vq[i].aeoi; rot_en = vq[i].rot_en;
            eoi = vq[i].eoi; seoi = vq[i].seoi; eoi_id = vq[i].eoi_id;
            set_prio = vq[i].set_prio; set_prio_id = vq[i].set_prio_id; inta = vq[i].inta;
            @(posedge clk);
            #1;
            check_all(i, vq[i].e_int, vq[i].e_ackv, vq[i].e_ackid, vq[i].e_sp, vq[i].e_isr, vq[i].e_low);
        end

        // Asynchronous reset while in REQ with a non-empty ISR.
        idle_inputs();
        irr = 8'h10;
        #2;
        rst_n = 1'b0;
        #1;
        check_all(100, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd7);
        @(posedge clk);
        #1;
        check_all(101, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd7);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all(102, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 3'd7);
        inta = 1'b1;
        @(posedge clk);
        #1;
        check_all(103, 1'b0, 8'h10, 3'd4, 1'b0, 8'h10, 3'd7);
        inta = 1'b0;
        irr = 8'h00;
        @(posedge clk);
        #1;
        check_all(104, 1'b0, 8'h00, 3'd4, 1'b0, 8'h10, 3'd7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
